// File: rtl/phase_scheduler.sv
// Round-robin phase scheduler for a two-road intersection with a pedestrian
// crossing. Latches North/East/Ped requests, grants one phase at a time with
// fixed green/walk, yellow and all-red intervals, and decodes the active-low
// lamp outputs directly from the registered state and owner.
module phase_scheduler #(
  parameter int GREEN_T  = 30,
  parameter int WALK_T   = 20,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             NorthSensor,
  input  logic             EastSensor,
  input  logic             PedButton,
  output logic             NorthRed,
  output logic             NorthYellow,
  output logic             NorthGreen,
  output logic             EastRed,
  output logic             EastYellow,
  output logic             EastGreen,
  output logic             PedWalk,
  output logic             PedDontWalk,
  output logic [2:0]       state,
  output logic [1:0]       owner,
  output logic [2:0]       pending,
  output logic [CNT_W-1:0] counter
);

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_DECIDE = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3
  } state_e;

  localparam logic [1:0] OWN_N = 2'd0;
  localparam logic [1:0] OWN_E = 2'd1;
  localparam logic [1:0] OWN_P = 2'd2;

  // Terminal counts: the counter runs 0..T-1 in each timed interval.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       next_owner_q, next_owner_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [2:0]       pending_q, pending_d;

  logic [2:0]       req;
  logic [2:0]       own_mask;
  logic [2:0]       other_req;
  logic [2:0]       clr;
  logic [1:0]       pick;

  assign req       = {PedButton, EastSensor, NorthSensor};
  assign own_mask  = 3'b001 << owner_q;
  assign other_req = pending_q & ~own_mask;

  // First pending requester after the owner in N -> E -> Ped -> N order.
  always_comb begin
    pick = OWN_N;
    case (owner_q)
      OWN_N:   pick = pending_q[1] ? OWN_E : OWN_P;
      OWN_E:   pick = pending_q[2] ? OWN_P : OWN_N;
      OWN_P:   pick = pending_q[0] ? OWN_N : OWN_E;
      default: pick = pending_q[0] ? OWN_N : (pending_q[1] ? OWN_E : OWN_P);
    endcase
  end

  // Next-state logic for the phase FSM, interval counter and request latches.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    next_owner_d = next_owner_q;
    counter_d    = counter_q + CNT_W'(1);
    case (state_q)
      ST_GREEN: begin
        if (counter_q == ((owner_q == OWN_P) ? WALK_LAST : GREEN_LAST)) begin
          state_d   = ST_DECIDE;
          counter_d = '0;
        end
      end
      ST_DECIDE: begin
        // Rest in the current phase until somebody asks for right-of-way.
        counter_d = '0;
        if (|other_req) begin
          next_owner_d = pick;
          // Pedestrians have no yellow; go straight to clearance.
          state_d      = (owner_q == OWN_P) ? ST_ALLRED : ST_YELLOW;
        end else if (|(pending_q & own_mask)) begin
          state_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (counter_q == YELLOW_LAST) begin
          state_d   = ST_ALLRED;
          counter_d = '0;
        end
      end
      ST_ALLRED: begin
        if (counter_q == ALLRED_LAST) begin
          state_d   = ST_GREEN;
          owner_d   = next_owner_q;
          counter_d = '0;
        end
      end
      default: begin
        state_d      = ST_GREEN;
        owner_d      = OWN_N;
        next_owner_d = OWN_N;
        counter_d    = '0;
      end
    endcase

    // A request is consumed on the cycle its phase is granted; the clear
    // beats a simultaneous new request from the same requester.
    clr = '0;
    if (state_d == ST_GREEN && state_q != ST_GREEN) begin
      clr = 3'b001 << owner_d;
    end
    pending_d = (pending_q | req) & ~clr;
  end

  // State registers with synchronous reset to GREEN/North.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GREEN;
      owner_q      <= OWN_N;
      next_owner_q <= OWN_N;
      counter_q    <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      next_owner_q <= next_owner_d;
      counter_q    <= counter_d;
      pending_q    <= pending_d;
    end
  end

  // Active-low lamp decode; anything not explicitly lit stays off.
  always_comb begin
    NorthRed    = 1'b1;
    NorthYellow = 1'b1;
    NorthGreen  = 1'b1;
    EastRed     = 1'b1;
    EastYellow  = 1'b1;
    EastGreen   = 1'b1;
    PedWalk     = 1'b1;
    PedDontWalk = 1'b1;
    case (state_q)
      ST_GREEN, ST_DECIDE: begin
        case (owner_q)
          OWN_N: begin
            NorthGreen  = 1'b0;
            EastRed     = 1'b0;
            PedDontWalk = 1'b0;
          end
          OWN_E: begin
            EastGreen   = 1'b0;
            NorthRed    = 1'b0;
            PedDontWalk = 1'b0;
          end
          OWN_P: begin
            NorthRed = 1'b0;
            EastRed  = 1'b0;
            PedWalk  = 1'b0;
          end
          default: begin
            NorthRed    = 1'b0;
            EastRed     = 1'b0;
            PedDontWalk = 1'b0;
          end
        endcase
      end
      ST_YELLOW: begin
        PedDontWalk = 1'b0;
        case (owner_q)
          OWN_N: begin
            NorthYellow = 1'b0;
            EastRed     = 1'b0;
          end
          OWN_E: begin
            EastYellow = 1'b0;
            NorthRed   = 1'b0;
          end
          default: begin
            NorthRed = 1'b0;
            EastRed  = 1'b0;
          end
        endcase
      end
      default: begin
        // All-red clearance, and a safe display for any illegal encoding.
        NorthRed    = 1'b0;
        EastRed     = 1'b0;
        PedDontWalk = 1'b0;
      end
    endcase
  end

  assign state   = state_q;
  assign owner   = owner_q;
  assign pending = pending_q;
  assign counter = counter_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: hand-computed cycle checkpoints for
// the main scheduling scenarios plus a per-cycle lamp safety monitor.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       NorthSensor = 1'b0;
  logic       EastSensor = 1'b0;
  logic       PedButton = 1'b0;
  logic       NorthRed, NorthYellow, NorthGreen;
  logic       EastRed, EastYellow, EastGreen;
  logic       PedWalk, PedDontWalk;
  logic [2:0] state;
  logic [1:0] owner;
  logic [2:0] pending;
  logic [4:0] counter;
  logic [7:0] lamps;

  int  errs = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  // Lamp vector {NR,NY,NG,ER,EY,EG,PW,PDW}, active-low.
  localparam int L_NG = 8'b1100_1110;  // North green
  localparam int L_EG = 8'b0111_1010;  // East green
  localparam int L_PW = 8'b0110_1101;  // Pedestrian walk
  localparam int L_NY = 8'b1010_1110;  // North yellow
  localparam int L_EY = 8'b0111_0110;  // East yellow
  localparam int L_AR = 8'b0110_1110;  // All red

  always #5 clk = ~clk;

  assign lamps = {NorthRed, NorthYellow, NorthGreen, EastRed,
                  EastYellow, EastGreen, PedWalk, PedDontWalk};

  phase_scheduler #(
    .GREEN_T(30), .WALK_T(20), .YELLOW_T(5), .ALLRED_T(2), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .NorthSensor(NorthSensor), .EastSensor(EastSensor), .PedButton(PedButton),
    .NorthRed(NorthRed), .NorthYellow(NorthYellow), .NorthGreen(NorthGreen),
    .EastRed(EastRed), .EastYellow(EastYellow), .EastGreen(EastGreen),
    .PedWalk(PedWalk), .PedDontWalk(PedDontWalk),
    .state(state), .owner(owner), .pending(pending), .counter(counter)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input string tag, input int c, input int st,
                           input int own, input int cnt, input int pend,
                           input int lmp);
    run_to(c);
    check($sformatf("%s@%0d state", tag, c), int'(state), st);
    check($sformatf("%s@%0d owner", tag, c), int'(owner), own);
    check($sformatf("%s@%0d counter", tag, c), int'(counter), cnt);
    check($sformatf("%s@%0d pending", tag, c), int'(pending), pend);
    check($sformatf("%s@%0d lamps", tag, c), int'(lamps), lmp);
  endtask

  // Lamp safety invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ped_one_hot", int'(PedWalk ^ PedDontWalk), 1);
      check("dual_green", int'(!NorthGreen && !EastGreen), 0);
      check("walk_with_green", int'(!PedWalk && (!NorthGreen || !EastGreen)), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_st, exp_cnt, exp_l;

    // Idle: North green for 30 cycles, then rest in DECIDE.
    do_reset();
    mon_en = 1'b1;
    expect_at("idle", 0, 0, 0, 0, 0, L_NG);
    for (int c = 1; c < 30; c++) begin
      run_to(c);
      check($sformatf("idle@%0d counter", c), int'(counter), c);
      check($sformatf("idle@%0d state", c), int'(state), 0);
    end
    expect_at("idle", 30, 1, 0, 0, 0, L_NG);
    for (int c = 31; c <= 200; c++) begin
      run_to(c);
      check($sformatf("rest@%0d state", c), int'(state), 1);
      check($sformatf("rest@%0d counter", c), int'(counter), 0);
      check($sformatf("rest@%0d lamps", c), int'(lamps), L_NG);
    end
    $display("tx idle_rest: done at cycle %0d", cyc);

    // East pulse at cycle 3; East also high on the edge that grants East.
    do_reset();
    run_to(3);
    EastSensor = 1'b1;
    tick();
    EastSensor = 1'b0;
    for (int c = 4; c <= 37; c++) begin
      run_to(c);
      if (c < 30) begin
        exp_st = 0; exp_cnt = c; exp_l = L_NG;
      end else if (c == 30) begin
        exp_st = 1; exp_cnt = 0; exp_l = L_NG;
      end else if (c <= 35) begin
        exp_st = 2; exp_cnt = c - 31; exp_l = L_NY;
      end else begin
        exp_st = 3; exp_cnt = c - 36; exp_l = L_AR;
      end
      check($sformatf("east@%0d state", c), int'(state), exp_st);
      check($sformatf("east@%0d counter", c), int'(counter), exp_cnt);
      check($sformatf("east@%0d pending", c), int'(pending), 2);
      check($sformatf("east@%0d lamps", c), int'(lamps), exp_l);
    end
    EastSensor = 1'b1;
    tick();
    EastSensor = 1'b0;
    expect_at("east_grant", 38, 0, 1, 0, 0, L_EG);
    expect_at("east_grant", 39, 0, 1, 1, 0, L_EG);
    $display("tx east_pulse: East granted at cycle 38");

    // Reset in the middle of YELLOW.
    do_reset();
    run_to(3);
    EastSensor = 1'b1;
    tick();
    EastSensor = 1'b0;
    expect_at("yel_mid", 33, 2, 0, 2, 2, L_NY);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("yel_reset state", int'(state), 0);
    check("yel_reset owner", int'(owner), 0);
    check("yel_reset counter", int'(counter), 0);
    check("yel_reset pending", int'(pending), 0);
    check("yel_reset lamps", int'(lamps), L_NG);
    $display("tx reset_in_yellow: recovered to North green");

    // All three requesters: service East, then Ped, then North.
    do_reset();
    run_to(5);
    NorthSensor = 1'b1; EastSensor = 1'b1; PedButton = 1'b1;
    tick();
    NorthSensor = 1'b0; EastSensor = 1'b0; PedButton = 1'b0;
    expect_at("rr", 6, 0, 0, 6, 7, L_NG);
    expect_at("rr", 30, 1, 0, 0, 7, L_NG);
    expect_at("rr", 31, 2, 0, 0, 7, L_NY);
    expect_at("rr", 35, 2, 0, 4, 7, L_NY);
    expect_at("rr", 36, 3, 0, 0, 7, L_AR);
    expect_at("rr", 37, 3, 0, 1, 7, L_AR);
    expect_at("rr", 38, 0, 1, 0, 5, L_EG);
    expect_at("rr", 67, 0, 1, 29, 5, L_EG);
    expect_at("rr", 68, 1, 1, 0, 5, L_EG);
    expect_at("rr", 69, 2, 1, 0, 5, L_EY);
    expect_at("rr", 73, 2, 1, 4, 5, L_EY);
    expect_at("rr", 74, 3, 1, 0, 5, L_AR);
    expect_at("rr", 76, 0, 2, 0, 1, L_PW);
    expect_at("rr", 95, 0, 2, 19, 1, L_PW);
    expect_at("rr", 96, 1, 2, 0, 1, L_PW);
    expect_at("rr", 97, 3, 2, 0, 1, L_AR);
    expect_at("rr", 98, 3, 2, 1, 1, L_AR);
    expect_at("rr", 99, 0, 0, 0, 0, L_NG);
    expect_at("rr", 129, 1, 0, 0, 0, L_NG);
    $display("tx round_robin: order East, Ped, North");

    // North held during its own green: re-grant without yellow.
    do_reset();
    run_to(10);
    NorthSensor = 1'b1;
    run_to(26);
    NorthSensor = 1'b0;
    expect_at("renew", 30, 1, 0, 0, 1, L_NG);
    expect_at("renew", 31, 0, 0, 0, 0, L_NG);
    for (int c = 32; c <= 70; c++) begin
      run_to(c);
      check($sformatf("renew@%0d no_yellow", c), int'(state == 3'd2), 0);
      if (c == 61) check("renew@61 decide", int'(state), 1);
    end
    $display("tx north_renew: same-owner re-grant");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Round-robin phase scheduler for a two-road intersection with a pedestrian crossing. Three requesters share the intersection right-of-way: North traffic, East traffic, and pedestrians. The block latches sensor and button requests, grants one phase at a time with fixed green/walk, yellow and all-red clearance intervals, and drives the active-low lamp outputs directly. It sits above the lamp drivers and replaces the two-way sensor check with a fair three-way arbiter.

## Interface
- GREEN_T, 30: vehicle green length in cycles.
- WALK_T, 20: pedestrian walk length in cycles.
- YELLOW_T, 5: yellow length in cycles.
- ALLRED_T, 2: all-red clearance length in cycles.
- CNT_W, 5: counter width. Every *_T must satisfy 1 ≤ T ≤ 2^CNT_W.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- NorthSensor  in  1  North vehicle request, level-sampled each cycle.
- EastSensor  in  1  East vehicle request.
- PedButton  in  1  pedestrian request.
- NorthRed, NorthYellow, NorthGreen, EastRed, EastYellow, EastGreen  out  1 each  vehicle lamps, active-low (0 = lit).
- PedWalk, PedDontWalk  out  1 each  pedestrian lamps, active-low.
- state  out  3  FSM state: GREEN=0, DECIDE=1, YELLOW=2, ALLRED=3.
- owner  out  2  phase holding right-of-way: North=0, East=1, Ped=2.
- pending  out  3  latched requests {Ped, East, North}.
- counter  out  CNT_W  interval counter.

## Operation
- Requests: pending[i] <= (pending[i] | in[i]) & ~clr[i]. clr[i] is high on the cycle the FSM enters GREEN with owner i. If set and clear happen in the same cycle, clear wins.
- GREEN: the owner phase is active. The counter runs 0..L-1, where L = WALK_T for Ped and GREEN_T otherwise. At counter == L-1 the FSM goes to DECIDE.
- DECIDE: the counter is held at 0 and the owner's lamps are held. Each cycle the FSM evaluates pending:
  - No bit set: stay in DECIDE (rest in the current phase indefinitely).
  - Only the owner's bit set: go to GREEN with the same owner. No yellow; the counter restarts; the bit is cleared.
  - Another bit set: latch next_owner = the first pending requester after owner in the order North→East→Ped→North, skipping owner. If owner is a vehicle, go to YELLOW; if owner is Ped, go directly to ALLRED.
- YELLOW: YELLOW_T cycles (counter 0..YELLOW_T-1), then ALLRED.
- ALLRED: ALLRED_T cycles, then GREEN. owner <= next_owner on this transition.
- The counter resets to 0 on every state transition.
- Lamps are decoded combinationally from registered state and owner. Every lamp not listed below is 1 (off).
  - GREEN/DECIDE, owner North: NorthGreen=0, EastRed=0, PedDontWalk=0.
  - GREEN/DECIDE, owner East: EastGreen=0, NorthRed=0, PedDontWalk=0.
  - GREEN/DECIDE, owner Ped: NorthRed=0, EastRed=0, PedWalk=0.
  - YELLOW: the owner's Yellow=0, the other road's Red=0, PedDontWalk=0.
  - ALLRED: NorthRed=0, EastRed=0, PedDontWalk=0.
- Exactly one of PedWalk/PedDontWalk is 0 at all times. Both road greens are never lit together, and no green is lit while PedWalk=0.
- Undefined state encodings return to GREEN/North with counter 0 on the next cycle.

## Timing
- Reset (synchronous, any state, including mid-interval): next cycle state=GREEN, owner=North, counter=0, pending=0, next_owner=North.
  - Lamps after reset: NorthGreen=0, EastRed=0, PedDontWalk=0, all others 1.
- An input asserted at edge k sets pending at edge k. A 1-cycle pulse is sufficient.
- Minimum handover from the end of GREEN to the next GREEN: 1 (DECIDE) + YELLOW_T + ALLRED_T cycles. With defaults this is 8 cycles from a vehicle owner, or 1 + ALLRED_T = 3 from Ped.
- Lamp outputs change in the same cycle as state/owner. There are no extra output registers.

## Test plan
- Reset, all inputs 0: GREEN/North with counter 0..29. At cycle 30 the FSM enters DECIDE and stays there through cycle 200. NorthGreen=0 and counter=0 throughout DECIDE.
- 1-cycle EastSensor pulse at cycle 3: pending=3'b010 until cycle 38. Expected sequence is DECIDE at 30, YELLOW 31–35 (NorthYellow=0), ALLRED 36–37, GREEN/East at 38. pending returns to 0.
- All three inputs pulsed during North green: service order East, then Ped (PedWalk=0 for 20 cycles, entered directly via ALLRED after the walk), then North. pending returns to 0.
- NorthSensor held during North green, no other requests: DECIDE for 1 cycle, then GREEN/North with counter=0. No YELLOW is ever observed.
- Reset asserted at counter=2 of YELLOW: the next cycle shows GREEN/North, counter=0, pending=0.
- EastSensor high on the exact cycle GREEN/East is entered: pending[1]=0 afterwards (clear wins). A monitor asserts the lamp-conflict invariants on every cycle.
